demux1x2_buf: RTL and testbench
===============================

// Module: demux1x2_buf
// PURPOSE
//  Buffered 1-to-2 demultiplexer with valid/ready handshake.
//  Steers each beat from one producer to output A (sel=0) or output B (sel=1), matching mux2x1 select polarity.
//  Typical use: route a shared memory/bus response stream to the fetch side (A) or the load/store side (B).
//  Each output has its own DEPTH-entry FIFO, so a stalled consumer only blocks beats addressed to it.
// PARAMETERS
//  data_width  32  width of in_data, out_a_data and out_b_data
//  DEPTH       2   entries per output FIFO; must be >= 1; need not be a power of 2
//  CW          $clog2(DEPTH+1)  derived localparam; width of the occupancy counts
// PORTS
//  clk          in   1           clock; all state updates on the rising edge
//  rst          in   1           asynchronous, active-high reset
//  in_valid     in   1           producer has a beat
//  in_sel       in   1           destination: 0 = A, 1 = B; sampled only with in_valid
//  in_data      in   data_width  beat payload
//  in_ready     out  1           beat is accepted this cycle
//  out_a_valid  out  1           FIFO A head is valid
//  out_a_data   out  data_width  FIFO A head entry
//  out_a_ready  in   1           consumer A takes the head
//  out_a_count  out  CW          FIFO A occupancy, 0..DEPTH
//  out_b_valid  out  1           FIFO B head is valid
//  out_b_data   out  data_width  FIFO B head entry
//  out_b_ready  in   1           consumer B takes the head
//  out_b_count  out  CW          FIFO B occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async assert, state held while rst=1):
//   - all counts and read/write pointers go to 0; all storage entries go to 0
//   - out_*_valid=0; out_*_data=0; in_ready reflects empty FIFOs, so it is 1
//  Handshake: a transfer happens when valid && ready are both 1 at the clock edge.
//   - in_valid must not depend on in_ready
//   - in_sel and in_data must stay stable while in_valid=1 && in_ready=0
//  Ready rule: in_ready = in_sel ? (out_b_count != DEPTH) : (out_a_count != DEPTH).
//   - this is purely combinational from in_sel and registered counts
//   - there is no combinational path from out_*_ready to in_ready
//   - a full FIFO does not accept a beat, even if it pops in the same cycle
//  Push: on an input transfer, in_data is written at wr_ptr of the selected FIFO, and that FIFO's wr_ptr and count advance.
//  Pop: on out_X_valid && out_X_ready, that FIFO's rd_ptr advances and its count decrements.
//  Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
//  Pointers wrap from DEPTH-1 to 0.
//  out_X_valid = (out_X_count != 0); out_X_data = storage[rd_ptr], taken directly from registers.
//  When out_X_valid=0, out_X_data holds the last popped entry, or 0 after reset.
//  Latency: a beat accepted at edge N appears at its output after edge N when the FIFO was empty (valid in cycle N+1).
//   - there is no bypass path, so minimum latency is 1 cycle
//  Ordering: FIFO order is preserved within each output; there is no ordering between A and B.
//  Independence: a full or stalled FIFO A never blocks pushes to B, and vice versa.
//  Reset mid-operation: all buffered beats are discarded; any in-flight input beat is not accepted.
// TESTING
//  1. Reset with in_valid=0: out_a/b_valid=0, counts=0, data=0, in_ready=1.
//  2. Push 0x11 sel=0, then 0x22 sel=1, with both readies=1:
//     - A shows 0x11 one cycle after its push
//     - B shows 0x22 one cycle after its push
//     - each count peaks at 1
//  3. DEPTH=2, out_a_ready=0, push 0xA0, 0xA1, 0xA2 sel=0:
//     - in_ready=0 on the third beat; out_a_count=2
//     - raise out_a_ready: A emits 0xA0, 0xA1, then 0xA2 is accepted
//  4. A full and stalled, push 0xB5 sel=1: accepted the same cycle; out_b_data=0xB5 next cycle; A is unchanged.
//  5. DEPTH=3, continuous push/pop on A for 10 beats 0..9:
//     - output sequence is 0..9 with pointer wrap
//     - count stays constant during simultaneous push/pop
//  6. Assert rst with A holding 2 beats and B holding 1:
//     - valids and counts drop to 0 immediately, with no clock edge
//     - after release, a new push 0x5A on A is the first beat out

Source files
------------

// File: rtl/demux1x2_buf.sv
// -----------------------------------------------------------------------------
// demux1x2_buf
//   Buffered 1-to-2 demultiplexer. Each beat from a single producer is steered
//   to output A (in_sel=0) or output B (in_sel=1). Both outputs have their own
//   DEPTH-entry FIFO, so a stalled consumer only holds back beats addressed to
//   it.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_sel/in_data   producer beat, destination select, payload
//   in_ready                  beat accepted this cycle
//   out_a_valid/data/ready    FIFO A head and consumer handshake
//   out_a_count               FIFO A occupancy, 0..DEPTH
//   out_b_valid/data/ready    FIFO B head and consumer handshake
//   out_b_count               FIFO B occupancy, 0..DEPTH
//
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// The sender must not make valid depend on ready, and must hold its payload
// (and in_sel on the input side) stable while valid=1 and ready=0.
// in_ready depends only on in_sel and the registered counts; it never looks at
// out_*_ready, so a full FIFO refuses a beat even if it pops that same cycle.
// -----------------------------------------------------------------------------
module demux1x2_buf #(
    parameter int data_width = 32,
    parameter int DEPTH      = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sel,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_a_valid,
    output logic [data_width-1:0] out_a_data,
    input  logic                  out_a_ready,
    output logic [CW-1:0]         out_a_count,
    output logic                  out_b_valid,
    output logic [data_width-1:0] out_b_data,
    input  logic                  out_b_ready,
    output logic [CW-1:0]         out_b_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Index 0 is FIFO A, index 1 is FIFO B.
    logic [data_width-1:0] mem_q   [2][DEPTH];
    logic [data_width-1:0] mem_d   [2][DEPTH];
    logic [PW-1:0]         wr_ptr_q[2];
    logic [PW-1:0]         wr_ptr_d[2];
    logic [PW-1:0]         rd_ptr_q[2];
    logic [PW-1:0]         rd_ptr_d[2];
    logic [CW-1:0]         count_q [2];
    logic [CW-1:0]         count_d [2];
    // Registered copy of the head entry. It tracks storage[rd_ptr] while the
    // FIFO holds data and freezes when the FIFO drains, so an empty output
    // keeps showing the last popped beat (0 after reset).
    logic [data_width-1:0] head_q  [2];
    logic [data_width-1:0] head_d  [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign out_ready = {out_b_ready, out_a_ready};

    always_comb begin
        in_ready = in_sel ? (count_q[1] != FULL) : (count_q[0] != FULL);
    end

    assign push[0] = in_valid && in_ready && !in_sel;
    assign push[1] = in_valid && in_ready &&  in_sel;
    assign pop[0]  = (count_q[0] != '0) && out_ready[0];
    assign pop[1]  = (count_q[1] != '0) && out_ready[1];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        for (int f = 0; f < 2; f++) begin
            if (push[f]) begin
                mem_d[f][wr_ptr_q[f]] = in_data;
                wr_ptr_d[f]           = next_ptr(wr_ptr_q[f]);
            end
            if (pop[f]) begin
                rd_ptr_d[f] = next_ptr(rd_ptr_q[f]);
            end
            if (push[f] && !pop[f]) begin
                count_d[f] = count_q[f] + 1'b1;
            end else if (!push[f] && pop[f]) begin
                count_d[f] = count_q[f] - 1'b1;
            end
            // Look through this cycle's write so a beat pushed into an empty
            // FIFO becomes the head right after the edge.
            if (count_d[f] != '0) begin
                head_d[f] = mem_d[f][rd_ptr_d[f]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < 2; f++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[f][e] <= '0;
                end
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                count_q[f]  <= '0;
                head_q[f]   <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign out_a_valid = (count_q[0] != '0);
    assign out_a_data  = head_q[0];
    assign out_a_count = count_q[0];
    assign out_b_valid = (count_q[1] != '0);
    assign out_b_data  = head_q[1];
    assign out_b_count = count_q[1];

endmodule

// File: tb/tb_demux1x2_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1x2_buf
//   Directed bench for demux1x2_buf. A DEPTH=2 instance runs a table of
//   single-cycle vectors plus a mid-operation reset sequence; a DEPTH=3
//   instance runs a continuous push/pop stream checked against an expected
//   queue.
// -----------------------------------------------------------------------------
module tb_demux1x2_buf;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DEPTH=2 instance ----------------
    logic        v2 = 1'b0, s2 = 1'b0, ar2 = 1'b0, br2 = 1'b0;
    logic [31:0] d2 = '0;
    logic        r2, av2, bv2;
    logic [31:0] ad2, bd2;
    logic [1:0]  ac2, bc2;

    demux1x2_buf #(.data_width(32), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_sel(s2), .in_data(d2), .in_ready(r2),
        .out_a_valid(av2), .out_a_data(ad2), .out_a_ready(ar2), .out_a_count(ac2),
        .out_b_valid(bv2), .out_b_data(bd2), .out_b_ready(br2), .out_b_count(bc2)
    );

    // ---------------- DEPTH=3 instance ----------------
    logic        v3 = 1'b0, s3 = 1'b0, ar3 = 1'b0, br3 = 1'b0;
    logic [31:0] d3 = '0;
    logic        r3, av3, bv3;
    logic [31:0] ad3, bd3;
    logic [1:0]  ac3, bc3;

    demux1x2_buf #(.data_width(32), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst),
        .in_valid(v3), .in_sel(s3), .in_data(d3), .in_ready(r3),
        .out_a_valid(av3), .out_a_data(ad3), .out_a_ready(ar3), .out_a_count(ac3),
        .out_b_valid(bv3), .out_b_data(bd3), .out_b_ready(br3), .out_b_count(bc3)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        ar;
        logic        br;
        logic        ir;   // in_ready before the edge
        logic        av;   // outputs after the edge
        logic [31:0] ad;
        logic [1:0]  ac;
        logic        bv;
        logic [31:0] bd;
        logic [1:0]  bc;
    } vec_t;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    // ---------------- driver tasks ----------------
    task automatic drive2(input logic v, input logic sel, input logic [31:0] d,
                          input logic ar, input logic br);
        v2 = v; s2 = sel; d2 = d; ar2 = ar; br2 = br;
    endtask

    task automatic check_u2(input string tag, input logic av, input logic [31:0] ad,
                            input logic [1:0] ac, input logic bv, input logic [31:0] bd,
                            input logic [1:0] bc);
        check({tag, " a_valid"}, 32'(av2), 32'(av));
        check({tag, " a_data"},  ad2, ad);
        check({tag, " a_count"}, 32'(ac2), 32'(ac));
        check({tag, " b_valid"}, 32'(bv2), 32'(bv));
        check({tag, " b_data"},  bd2, bd);
        check({tag, " b_count"}, 32'(bc2), 32'(bc));
    endtask

    // ---------------- test ----------------
    initial begin
        //                v  sel  data      ar br | ir  av  ad        ac     bv  bd        bc
        // two-destination routing, one-cycle latency
        vecs[0]  = '{H, L, 32'h11, H, H,  H,  H, 32'h11, 2'd1,  L, 32'h00, 2'd0};
        vecs[1]  = '{H, H, 32'h22, H, H,  H,  L, 32'h11, 2'd0,  H, 32'h22, 2'd1};
        vecs[2]  = '{L, H, 32'h00, H, H,  H,  L, 32'h11, 2'd0,  L, 32'h22, 2'd0};
        // fill A while stalled; third beat refused
        vecs[3]  = '{H, L, 32'hA0, L, L,  H,  H, 32'hA0, 2'd1,  L, 32'h22, 2'd0};
        vecs[4]  = '{H, L, 32'hA1, L, L,  H,  H, 32'hA0, 2'd2,  L, 32'h22, 2'd0};
        vecs[5]  = '{H, L, 32'hA2, L, L,  L,  H, 32'hA0, 2'd2,  L, 32'h22, 2'd0};
        // B still accepts while A is full
        vecs[6]  = '{H, H, 32'hB5, L, L,  H,  H, 32'hA0, 2'd2,  H, 32'hB5, 2'd1};
        // full A pops but does not accept in the same cycle
        vecs[7]  = '{H, L, 32'hA2, H, L,  L,  H, 32'hA1, 2'd1,  H, 32'hB5, 2'd1};
        // push and pop together, pointer wrap on the write side
        vecs[8]  = '{H, L, 32'hA2, H, L,  H,  H, 32'hA2, 2'd1,  H, 32'hB5, 2'd1};
        // drain both; data holds last popped
        vecs[9]  = '{L, L, 32'h00, H, H,  H,  L, 32'hA2, 2'd0,  L, 32'hB5, 2'd0};
        vecs[10] = '{H, H, 32'hC3, H, H,  H,  L, 32'hA2, 2'd0,  H, 32'hC3, 2'd1};
        vecs[11] = '{L, H, 32'h00, L, L,  H,  L, 32'hA2, 2'd0,  H, 32'hC3, 2'd1};

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(r2), 32'd1);
        check_u2("rst", L, 32'h0, 2'd0, L, 32'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(r2), 32'd1);
        check_u2("post-rst", L, 32'h0, 2'd0, L, 32'h0, 2'd0);

        // ---- table-driven vectors on DEPTH=2 ----
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive2(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(r2), 32'(vecs[i].ir));
            @(posedge clk);
            #1;
            check_u2($sformatf("v%0d", i), vecs[i].av, vecs[i].ad, vecs[i].ac,
                     vecs[i].bv, vecs[i].bd, vecs[i].bc);
        end

        // ---- DEPTH=3 continuous stream on A, values 0..9 ----
        @(negedge clk);
        v3 = 1'b1; s3 = 1'b0; d3 = 32'd0; ar3 = 1'b0;
        exp_q.push_back(32'd0);
        @(posedge clk);
        #1;
        check("d3 count after beat0", 32'(ac3), 32'd1);
        @(negedge clk);
        d3 = 32'd1;
        exp_q.push_back(32'd1);
        @(posedge clk);
        #1;
        check("d3 count after beat1", 32'(ac3), 32'd2);
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            d3 = 32'(k);
            ar3 = 1'b1;
            #1;
            check($sformatf("d3 in_ready k=%0d", k), 32'(r3), 32'd1);
            check($sformatf("d3 a_valid k=%0d", k), 32'(av3), 32'd1);
            if (exp_q.size() != 0) begin
                check($sformatf("d3 pop k=%0d", k), ad3, exp_q.pop_front());
            end else begin
                check($sformatf("d3 queue k=%0d", k), 32'(exp_q.size()), 32'd1);
            end
            exp_q.push_back(32'(k));
            @(posedge clk);
            #1;
            check($sformatf("d3 count k=%0d", k), 32'(ac3), 32'd2);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            v3 = 1'b0;
            ar3 = 1'b1;
            #1;
            check($sformatf("d3 drain valid %0d", k), 32'(av3), 32'd1);
            if (exp_q.size() != 0) begin
                check($sformatf("d3 drain pop %0d", k), ad3, exp_q.pop_front());
            end else begin
                check($sformatf("d3 drain queue %0d", k), 32'(exp_q.size()), 32'd1);
            end
            @(posedge clk);
        end
        #1;
        check("d3 final count", 32'(ac3), 32'd0);
        check("d3 final valid", 32'(av3), 32'd0);
        check("d3 final data held", ad3, 32'd9);
        check("d3 queue empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        ar3 = 1'b0;

        // ---- reset mid-operation on DEPTH=2 (B already holds 0xC3) ----
        @(negedge clk);
        drive2(H, L, 32'h61, L, L);
        @(negedge clk);
        drive2(H, L, 32'h62, L, L);
        @(negedge clk);
        drive2(L, L, 32'h00, L, L);
        #1;
        check_u2("pre-rst2", H, 32'h61, 2'd2, H, 32'hC3, 2'd1);
        // Asserted mid-cycle: the next rising edge is 4 time units away.
        drive2(H, L, 32'hEE, L, L);
        rst = 1'b1;
        #1;
        check_u2("async rst", L, 32'h0, 2'd0, L, 32'h0, 2'd0);
        check("async rst in_ready", 32'(r2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive2(L, L, 32'h00, L, L);
        @(posedge clk);
        #1;
        check_u2("after rst2", L, 32'h0, 2'd0, L, 32'h0, 2'd0);
        @(negedge clk);
        drive2(H, L, 32'h5A, H, H);
        @(posedge clk);
        #1;
        check_u2("first after rst2", H, 32'h5A, 2'd1, L, 32'h0, 2'd0);
        @(negedge clk);
        drive2(L, L, 32'h00, H, H);
        @(posedge clk);
        #1;
        check_u2("drain after rst2", L, 32'h5A, 2'd0, L, 32'h0, 2'd0);

        // ---- report ----
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
